pipe_feat_in: RTL and testbench

Input-side pipeline stage between the wrapper's source stream (axi_source) and the HWCE engine's x_in stream. It mirrors the output-side pooling pipe stage. It is armed by start_i and accepts exactly image_width_i/NPX beats per row for feat_height_i rows, through a 2-entry skid buffer, so throughput is one beat per cycle with a registered source-side ready. When the last beat has left the buffer, it drains, pulses done_o and returns to idle. This guarantees the engine never sees extra or missing beats.

---
 rtl/pipe_feat_in_pkg.sv | 26 ++
 rtl/pipe_feat_in_stream_skid2.sv | 79 +++++++
 rtl/pipe_feat_in.sv | 171 +++++++++++++++++
 tb/tb_pipe_feat_in.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_feat_in_pkg.sv
// Shared types and helpers for the input-side feature pipe stage.
// Provides the FSM state encoding and the start-time configuration check.
package pipe_feat_in_pkg;

    typedef enum logic [1:0] {
        IDLE_F  = 2'd0,
        RUN_F   = 2'd1,
        DRAIN_F = 2'd2,
        DONE_F  = 2'd3
    } fsm_pipe_feat_in;

    // A feature is unusable when it has no pixels or when its width does not
    // split into whole beats; mask is NPX-1 (NPX is a power of two).
    function automatic logic cfg_is_bad(input logic [15:0] width,
                                        input logic [15:0] height,
                                        input logic [15:0] mask);
        logic bad_s;
        if ((width == 16'd0) || (height == 16'd0)) begin
            bad_s = 1'b1;
        end else begin
            bad_s = ((width & mask) != 16'd0);
        end
        return bad_s;
    endfunction

endpackage

// File: rtl/pipe_feat_in_stream_skid2.sv
// stream_skid2: generic 2-entry FIFO skid buffer.
// Ports:
//   clk_gated, rst_n (sync, active-low), clear (sync soft clear)
//   push_i / data_i : write one payload (ignored when full)
//   pop_i           : drop the head entry (ignored when empty)
//   data_o          : head payload, forced to zero when empty
//   valid_o         : buffer not empty
//   occ_o           : current occupancy 0..2
//   occ_next_o      : occupancy after this cycle's push/pop
module stream_skid2 #(
    parameter int W = 8
) (
    input  logic         clk_gated,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic [1:0]   occ_o,
    output logic [1:0]   occ_next_o
);

    logic [W-1:0] mem_r [0:1];
    logic         rd_r;
    logic         wr_r;
    logic [1:0]   occ_r;
    logic         push_ok_s;
    logic         pop_ok_s;
    logic [1:0]   occ_next_s;

    assign push_ok_s = push_i && (occ_r != 2'd2);
    assign pop_ok_s  = pop_i && (occ_r != 2'd0);

    // Next occupancy: a simultaneous push and pop leaves it unchanged.
    always_comb begin
        occ_next_s = occ_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   occ_next_s = occ_r + 2'd1;
            2'b01:   occ_next_s = occ_r - 2'd1;
            default: occ_next_s = occ_r;
        endcase
    end

    // Storage, read/write pointers and occupancy.
    always_ff @(posedge clk_gated) begin
        if (!rst_n || clear) begin
            mem_r[0] <= {W{1'b0}};
            mem_r[1] <= {W{1'b0}};
            rd_r     <= 1'b0;
            wr_r     <= 1'b0;
            occ_r    <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_r] <= data_i;
                wr_r        <= ~wr_r;
            end
            if (pop_ok_s) begin
                rd_r <= ~rd_r;
            end
            occ_r <= occ_next_s;
        end
    end

    // Head entry is masked so stale or unknown payload never leaks out.
    always_comb begin
        if (occ_r != 2'd0) begin
            data_o = mem_r[rd_r];
        end else begin
            data_o = {W{1'b0}};
        end
    end

    assign valid_o    = (occ_r != 2'd0);
    assign occ_o      = occ_r;
    assign occ_next_o = occ_next_s;

endmodule

// File: rtl/pipe_feat_in.sv
// pipe_feat_in: input-side pipe stage between the wrapper source stream and
// the engine x_in stream. Armed by start_i, it accepts exactly
// (image_width_i/NPX)*feat_height_i beats through a 2-entry skid buffer,
// drains, pulses done_o and returns to idle.
// Ports:
//   clk_gated, rst_n (sync, active-low), clear (sync soft clear)
//   start_i, image_width_i, feat_height_i : arm pulse and feature size
//   axi_source_*  : upstream stream (TREADY registered)
//   x_in_*        : downstream stream to the engine (zero payload when idle)
//   busy_o        : RUN or DRAIN
//   done_o        : one-cycle end-of-feature pulse
//   cfg_err_o     : sticky bad-config flag, cleared by the next good start
module pipe_feat_in #(
    parameter int AXI_WIDTH = 32,
    parameter int NPX       = 4
) (
    input  logic                          clk_gated,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          start_i,
    input  logic [15:0]                   image_width_i,
    input  logic [15:0]                   feat_height_i,
    input  logic                          axi_source_TVALID_i,
    output logic                          axi_source_TREADY_o,
    input  logic [NPX-1:0][AXI_WIDTH-1:0] axi_source_TDATA_i,
    input  logic [AXI_WIDTH/8-1:0]        axi_source_TKEEP_i,
    output logic                          x_in_TVALID_o,
    input  logic                          x_in_TREADY_i,
    output logic [NPX-1:0][AXI_WIDTH-1:0] x_in_TDATA_o,
    output logic [AXI_WIDTH/8-1:0]        x_in_TKEEP_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          cfg_err_o
);

    import pipe_feat_in_pkg::*;

    localparam int          DW    = NPX * AXI_WIDTH;
    localparam int          KW    = AXI_WIDTH / 8;
    localparam int          PW    = DW + KW;
    localparam logic [15:0] NPX16 = 16'(NPX);
    localparam logic [15:0] MASK16 = 16'(NPX - 1);

    fsm_pipe_feat_in state_r;
    fsm_pipe_feat_in state_next_s;

    logic [15:0]   width_r;
    logic [15:0]   height_r;
    logic [15:0]   cnt_w_r;
    logic [15:0]   cnt_h_r;
    logic          ready_r;
    logic          busy_r;
    logic          done_r;
    logic          cfg_err_r;

    logic          push_s;
    logic          pop_s;
    logic          valid_s;
    logic [1:0]    occ_s;
    logic [1:0]    occ_next_s;
    logic          row_end_s;
    logic          last_push_s;
    logic          cfg_bad_s;
    logic [PW-1:0] head_s;

    assign push_s      = axi_source_TVALID_i && ready_r;
    assign pop_s       = valid_s && x_in_TREADY_i;
    assign cfg_bad_s   = cfg_is_bad(image_width_i, feat_height_i, MASK16);
    // width >= NPX is guaranteed once in RUN, so width-NPX cannot underflow.
    assign row_end_s   = (cnt_w_r == (width_r - NPX16));
    assign last_push_s = push_s && row_end_s && (cnt_h_r == (height_r - 16'd1));

    stream_skid2 #(
        .W (PW)
    ) u_skid (
        .clk_gated  (clk_gated),
        .rst_n      (rst_n),
        .clear      (clear),
        .push_i     (push_s),
        .data_i     ({axi_source_TDATA_i, axi_source_TKEEP_i}),
        .pop_i      (pop_s),
        .data_o     (head_s),
        .valid_o    (valid_s),
        .occ_o      (occ_s),
        .occ_next_o (occ_next_s)
    );

    // Next-state decode for the feature FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE_F: begin
                if (start_i) begin
                    if (cfg_bad_s) begin
                        state_next_s = DONE_F;
                    end else begin
                        state_next_s = RUN_F;
                    end
                end else begin
                    state_next_s = IDLE_F;
                end
            end
            RUN_F: begin
                if (last_push_s) begin
                    if (occ_next_s == 2'd0) begin
                        state_next_s = DONE_F;
                    end else begin
                        state_next_s = DRAIN_F;
                    end
                end else begin
                    state_next_s = RUN_F;
                end
            end
            DRAIN_F: begin
                if (occ_next_s == 2'd0) begin
                    state_next_s = DONE_F;
                end else begin
                    state_next_s = DRAIN_F;
                end
            end
            DONE_F:  state_next_s = IDLE_F;
            default: state_next_s = IDLE_F;
        endcase
    end

    // FSM state, beat counters, latched configuration and registered outputs.
    always_ff @(posedge clk_gated) begin
        if (!rst_n || clear) begin
            state_r   <= IDLE_F;
            width_r   <= 16'd0;
            height_r  <= 16'd0;
            cnt_w_r   <= 16'd0;
            cnt_h_r   <= 16'd0;
            ready_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            cfg_err_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            // Ready only while more beats are owed and a slot will be free.
            ready_r <= (state_next_s == RUN_F) && (occ_next_s < 2'd2) && !last_push_s;
            busy_r  <= (state_next_s == RUN_F) || (state_next_s == DRAIN_F);
            done_r  <= (state_next_s == DONE_F);
            if ((state_r == IDLE_F) && start_i) begin
                width_r   <= image_width_i;
                height_r  <= feat_height_i;
                cnt_w_r   <= 16'd0;
                cnt_h_r   <= 16'd0;
                cfg_err_r <= cfg_bad_s;
            end else if (push_s) begin
                if (row_end_s) begin
                    cnt_w_r <= 16'd0;
                    cnt_h_r <= cnt_h_r + 16'd1;
                end else begin
                    cnt_w_r <= cnt_w_r + NPX16;
                end
            end else begin
                cnt_w_r <= cnt_w_r;
            end
        end
    end

    assign axi_source_TREADY_o = ready_r;
    assign x_in_TVALID_o       = valid_s;
    assign x_in_TDATA_o        = head_s[PW-1:KW];
    assign x_in_TKEEP_o        = head_s[KW-1:0];
    assign busy_o              = busy_r;
    assign done_o              = done_r;
    assign cfg_err_o           = cfg_err_r;

endmodule

// File: tb/tb_pipe_feat_in.sv
// Directed, scoreboard-checked bench for pipe_feat_in (AXI_WIDTH=32, NPX=4).
module tb_pipe_feat_in;

    logic              clk_gated = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              start_i;
    logic [15:0]       image_width_i;
    logic [15:0]       feat_height_i;
    logic              src_valid;
    logic              src_ready;
    logic [3:0][31:0]  src_data;
    logic [3:0]        src_keep;
    logic              x_valid;
    logic              eng_ready;
    logic [3:0][31:0]  x_data;
    logic [3:0]        x_keep;
    logic              busy_o;
    logic              done_o;
    logic              cfg_err_o;

    always #5 clk_gated = ~clk_gated;

    pipe_feat_in #(.AXI_WIDTH(32), .NPX(4)) dut (
        .clk_gated           (clk_gated),
        .rst_n               (rst_n),
        .clear               (clear),
        .start_i             (start_i),
        .image_width_i       (image_width_i),
        .feat_height_i       (feat_height_i),
        .axi_source_TVALID_i (src_valid),
        .axi_source_TREADY_o (src_ready),
        .axi_source_TDATA_i  (src_data),
        .axi_source_TKEEP_i  (src_keep),
        .x_in_TVALID_o       (x_valid),
        .x_in_TREADY_i       (eng_ready),
        .x_in_TDATA_o        (x_data),
        .x_in_TKEEP_o        (x_keep),
        .busy_o              (busy_o),
        .done_o              (done_o),
        .cfg_err_o           (cfg_err_o)
    );

    int checks = 0;
    int errors = 0;
    logic [131:0] exp_q[$];
    int n_acc, n_out, n_exp, n_done;
    int src_idx, src_limit, exp_pushed;
    int test_id, mode, cyc;
    int last_acc_cyc, done_cyc, start_cyc;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [131:0] make_beat(input int t, input int k);
        logic [131:0] b;
        for (int l = 0; l < 4; l++) begin
            b[4 + l*32 +: 32] = {8'(t), 16'(k), 8'(l)};
        end
        b[3:0] = 4'(k);
        return b;
    endfunction

    // Present the current source beat; record it as expected the first time
    // a beat that belongs to the feature is offered.
    task automatic set_src();
        logic [131:0] b;
        if (src_idx < src_limit) begin
            b = make_beat(test_id, src_idx);
            src_valid = 1'b1;
            src_data  = b[131:4];
            src_keep  = b[3:0];
            if ((src_idx < n_exp) && (src_idx == exp_pushed)) begin
                exp_q.push_back(b);
                exp_pushed++;
            end
        end else begin
            src_valid = 1'b0;
            src_data  = '0;
            src_keep  = 4'd0;
        end
    endtask

    task automatic tick();
        int occ;
        logic fire;
        logic [131:0] e;
        @(negedge clk_gated);
        occ = n_acc - n_out;
        chk("x_valid_vs_model", 256'(x_valid), 256'(occ != 0));
        if (!x_valid) chk("idle_payload_zero", 256'({x_data, x_keep}), 256'(0));
        if (occ >= 2) chk("ready_when_full", 256'(src_ready), 256'(0));
        if (n_acc >= n_exp) chk("ready_after_last", 256'(src_ready), 256'(0));
        if (x_valid && eng_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 256'(1), 256'(0));
            end else begin
                e = exp_q.pop_front();
                chk("beat_data", 256'({x_data, x_keep}), 256'(e));
            end
            n_out++;
        end
        fire = src_valid && src_ready;
        if (fire) begin
            n_acc++;
            last_acc_cyc = cyc;
        end
        if (done_o) begin
            n_done++;
            done_cyc = cyc;
        end
        @(posedge clk_gated);
        #1;
        cyc++;
        if (fire) src_idx++;
        set_src();
        eng_ready = (mode == 0) ? 1'b1 : ((mode == 1) ? cyc[0] : 1'b0);
    endtask

    task automatic pulse_start(input int w, input int h);
        image_width_i = 16'(w);
        feat_height_i = 16'(h);
        start_i = 1'b1;
        start_cyc = cyc;
        tick();
        start_i = 1'b0;
    endtask

    task automatic start_feat(input int t, input int w, input int h, input int lim, input int md);
        test_id = t;
        mode = md;
        eng_ready = (md == 2) ? 1'b0 : 1'b1;
        n_acc = 0; n_out = 0; src_idx = 0; exp_pushed = 0;
        n_exp = ((w == 0) || (h == 0) || ((w % 4) != 0)) ? 0 : (w / 4) * h;
        src_limit = lim;
        set_src();
        pulse_start(w, h);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        int k;
        d0 = n_done;
        k = 0;
        while ((n_done == d0) && (k < budget)) begin
            tick();
            k++;
        end
        chk("done_within_budget", 256'(n_done > d0), 256'(1));
    endtask

    task automatic drop_model();
        exp_q.delete();
        n_acc = 0; n_out = 0; n_exp = 0;
        src_idx = 0; src_limit = 0; exp_pushed = 0;
        set_src();
    endtask

    // Abort a stalled feature with reset (use_clear=0) or soft clear (1).
    task automatic abort_feat(input int t, input int use_clear);
        int d0;
        int k;
        start_feat(t, 16, 4, 16, 1);
        k = 0;
        while ((n_acc < 3) && (k < 100)) begin
            tick();
            k++;
        end
        chk("abort_reached_3_beats", 256'(n_acc >= 3), 256'(1));
        mode = 2;
        eng_ready = 1'b0;
        src_limit = 0;
        set_src();
        if (use_clear != 0) clear = 1'b1; else rst_n = 1'b0;
        d0 = n_done;
        tick();
        drop_model();
        chk("abort_outputs_zero",
            256'({src_ready, x_valid, x_data, x_keep, busy_o, done_o, cfg_err_o}), 256'(0));
        rst_n = 1'b1;
        clear = 1'b0;
        mode = 0;
        eng_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_no_done", 256'(n_done), 256'(d0));
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; clear = 1'b0; start_i = 1'b0;
        image_width_i = 16'd0; feat_height_i = 16'd0;
        src_valid = 1'b0; src_data = '0; src_keep = 4'd0; eng_ready = 1'b1;
        n_acc = 0; n_out = 0; n_exp = 0; n_done = 0;
        src_idx = 0; src_limit = 0; exp_pushed = 0;
        test_id = 0; mode = 0; cyc = 0;
        last_acc_cyc = 0; done_cyc = 0; start_cyc = 0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        tick();
        chk("reset_outputs_zero",
            256'({src_ready, x_valid, x_data, x_keep, busy_o, done_o, cfg_err_o}), 256'(0));

        // 1: 8x2, free-flowing, extra source beats offered
        d0 = n_done;
        start_feat(1, 8, 2, 6, 0);
        chk("t1_busy", 256'(busy_o), 256'(1));
        wait_done(100);
        chk("t1_accepted", 256'(n_acc), 256'(4));
        chk("t1_delivered", 256'(n_out), 256'(4));
        chk("t1_done_latency", 256'(done_cyc - last_acc_cyc), 256'(2));
        for (int i = 0; i < 3; i++) tick();
        chk("t1_single_done", 256'(n_done), 256'(d0 + 1));
        chk("t1_queue_empty", 256'(exp_q.size()), 256'(0));
        chk("t1_idle_busy", 256'(busy_o), 256'(0));

        // 2: 8x2 with engine ready toggling
        start_feat(2, 8, 2, 4, 1);
        wait_done(100);
        chk("t2_delivered", 256'(n_out), 256'(4));
        chk("t2_queue_empty", 256'(exp_q.size()), 256'(0));

        // 3: 16x3 with 20 source beats offered
        start_feat(3, 16, 3, 20, 0);
        wait_done(200);
        for (int i = 0; i < 4; i++) tick();
        chk("t3_accepted", 256'(n_acc), 256'(12));
        chk("t3_delivered", 256'(n_out), 256'(12));
        chk("t3_beat13_pending", 256'(src_valid && !src_ready), 256'(1));

        // 4: width 6 is rejected; a following good start clears the flag
        start_feat(4, 6, 2, 2, 0);
        chk("t4_cfg_err", 256'(cfg_err_o), 256'(1));
        wait_done(20);
        chk("t4_done_latency", 256'(done_cyc - start_cyc), 256'(1));
        chk("t4_no_accept", 256'(n_acc), 256'(0));
        tick();
        start_feat(41, 8, 1, 2, 0);
        chk("t4_cfg_err_cleared", 256'(cfg_err_o), 256'(0));
        wait_done(100);
        chk("t4_good_accepted", 256'(n_acc), 256'(2));

        // 5: reset mid-feature, then a full feature
        abort_feat(5, 0);
        start_feat(51, 16, 4, 16, 0);
        wait_done(200);
        chk("t5_delivered", 256'(n_out), 256'(16));
        chk("t5_queue_empty", 256'(exp_q.size()), 256'(0));

        // 6: start during RUN is ignored
        start_feat(6, 8, 2, 10, 0);
        tick();
        pulse_start(16, 4);
        wait_done(100);
        for (int i = 0; i < 3; i++) tick();
        chk("t6_accepted", 256'(n_acc), 256'(4));
        chk("t6_queue_empty", 256'(exp_q.size()), 256'(0));

        // 7: soft clear mid-feature, then a full feature
        abort_feat(7, 1);
        start_feat(71, 8, 2, 4, 1);
        wait_done(100);
        chk("t7_delivered", 256'(n_out), 256'(4));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
